// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline run controller.
// Contents:
//   run_state_t   - controller states IDLE, RESET, RUN, DONE
//   DEFAULT_CNT_W - default width of the cycle and retire counters
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/pc_halt_detect.sv
// Halt detector for the controlled core.
// It watches the fetch PC while sampling is enabled. A halt is reported
// once HALT_STABLE consecutive samples carry the same PC.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   clear     - forgets the PC history (used when a new run starts)
//   sample_en - high on cycles whose PC must be observed
//   pc        - fetch PC of the core
//   halt      - high in the sample cycle that completes the stable run
module pc_halt_detect #(
    parameter int ADDR_W      = 32,
    parameter int HALT_STABLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [ADDR_W-1:0] pc,
    output logic              halt
);

    localparam int SW = $clog2(HALT_STABLE) + 1;
    localparam logic [SW-1:0] CNT_LAST = SW'(HALT_STABLE - 1);
    localparam logic [SW-1:0] CNT_FIRE = SW'(HALT_STABLE - 2);

    logic [ADDR_W-1:0] last_pc;
    logic              last_valid;
    logic [SW-1:0]     stable_cnt;
    logic              pc_same;

    // The first sample after a clear only loads the history; it cannot
    // match a stale PC left over from an earlier run.
    assign pc_same = last_valid && (pc == last_pc);

    // stable_cnt counts matches against the previous sample, so it reaches
    // HALT_STABLE-1 when HALT_STABLE samples in a row are equal.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            last_pc    <= '0;
            last_valid <= 1'b0;
            stable_cnt <= '0;
        end else if (sample_en) begin
            last_pc    <= pc;
            last_valid <= 1'b1;
            if (!pc_same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_LAST) begin
                stable_cnt <= stable_cnt + SW'(1);
            end
        end
    end

    // Combinational so the controller can stop in the same cycle the
    // count becomes HALT_STABLE-1.
    assign halt = sample_en && pc_same && (stable_cnt == CNT_FIRE);

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller for a pipelined core: holds the core in reset for a fixed
// number of cycles after start, lets it run, and stops it when it halts
// (PC stable), exceeds its cycle budget, or is aborted.
// Optional feature: define PIPELINE_RUN_CTRL_RETIRE_EN to count retired
// instructions; otherwise retire_cnt_o is 0 and retire_i is ignored.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start_i           - pulse requesting a run (accepted in IDLE or DONE)
//   abort_i           - stops RESET/RUN, returning to IDLE
//   pc_i              - fetch PC of the core (halt detection)
//   retire_i          - pulse per retired instruction
//   core_rst_o        - reset to the core
//   core_en_o         - run permission to the core
//   busy_o, done_o    - state indications
//   halted_o          - run ended by a stable PC
//   timeout_o         - run ended by the cycle budget
//   cycle_cnt_o       - RUN cycles of the current/last run (saturating)
//   retire_cnt_o      - retired instructions during RUN (saturating)
module pipeline_run_ctrl
    import pipeline_pkg::*;
#(
    parameter int RST_CYCLES  = 2,
    parameter int RUN_CYCLES  = 50,
    parameter int HALT_STABLE = 4,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              retire_i,
    output logic              core_rst_o,
    output logic              core_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              halted_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);

    run_state_t    state;
    run_state_t    next_state;
    logic [RW-1:0] rst_cnt;
    logic          start_accept;
    logic          run_step;
    logic          timeout_hit;
    logic          halt;

    assign start_accept = start_i && ((state == IDLE) || (state == DONE));
    // A RUN cycle that is not aborted advances counters and may finish.
    assign run_step     = (state == RUN) && !abort_i;
    assign timeout_hit  = (RUN_CYCLES != 0) && (cycle_cnt_o == RUN_LAST);

    pc_halt_detect #(
        .ADDR_W      (ADDR_W),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_accept),
        .sample_en (run_step),
        .pc        (pc_i),
        .halt      (halt)
    );

    // Abort wins over halt/timeout; start is only honoured in IDLE/DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start_i) next_state = RESET;
            RESET: begin
                if (abort_i) begin
                    next_state = IDLE;
                end else if (rst_cnt == RST_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    next_state = IDLE;
                end else if (halt || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE:  if (start_i) next_state = RESET;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            core_rst_o  <= 1'b1;
            core_en_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            halted_o    <= 1'b0;
            timeout_o   <= 1'b0;
            cycle_cnt_o <= '0;
        end else begin
            state      <= next_state;
            rst_cnt    <= ((state == RESET) && (next_state == RESET)) ? rst_cnt + RW'(1) : '0;
            core_rst_o <= (next_state == IDLE) || (next_state == RESET);
            core_en_o  <= (next_state == RUN);
            busy_o     <= (next_state == RESET) || (next_state == RUN);
            done_o     <= (next_state == DONE);
            if (start_accept) begin
                cycle_cnt_o <= '0;
                halted_o    <= 1'b0;
                timeout_o   <= 1'b0;
            end else if (run_step) begin
                if (cycle_cnt_o != '1) begin
                    cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
                end
                if (halt || timeout_hit) begin
                    halted_o  <= halt;
                    timeout_o <= timeout_hit;
                end
            end
        end
    end

`ifdef PIPELINE_RUN_CTRL_RETIRE_EN
    logic [CNT_W-1:0] retire_cnt;

    // Retirements count only in non-aborted RUN cycles and saturate.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            retire_cnt <= '0;
        end else if (run_step && retire_i && (retire_cnt != '1)) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt_o = retire_cnt;
`else
    logic unused_retire;

    assign unused_retire = retire_i;
    assign retire_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl with default parameters.
// A run-level model (mode, remaining reset cycles, elapsed RUN cycles,
// PC history window) predicts every output; a negedge process compares
// the DUT with it each cycle, and literal checks pin key results.
module tb_pipeline_run_ctrl;

    localparam int RST_CYCLES  = 2;
    localparam int RUN_CYCLES  = 50;
    localparam int HALT_STABLE = 4;
    localparam int ADDR_W      = 32;
    localparam int CNT_W       = 16;
`ifdef PIPELINE_RUN_CTRL_RETIRE_EN
    localparam bit RETIRE_ON = 1'b1;
`else
    localparam bit RETIRE_ON = 1'b0;
`endif
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_RESET = 1, M_RUN = 2, M_DONE = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic              retire_i = 1'b0;
    logic [ADDR_W-1:0] pc_i = '0;
    logic              core_rst_o, core_en_o, busy_o, done_o, halted_o, timeout_o;
    logic [CNT_W-1:0]  cycle_cnt_o, retire_cnt_o;

    pipeline_run_ctrl #(
        .RST_CYCLES (RST_CYCLES),
        .RUN_CYCLES (RUN_CYCLES),
        .HALT_STABLE(HALT_STABLE),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .pc_i        (pc_i),
        .retire_i    (retire_i),
        .core_rst_o  (core_rst_o),
        .core_en_o   (core_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .halted_o    (halted_o),
        .timeout_o   (timeout_o),
        .cycle_cnt_o (cycle_cnt_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_failed   = 0;
    bit cmp_en     = 1'b0;

    // Model state
    int                m_mode    = M_IDLE;
    int                m_rst_left = 0;
    int                m_elapsed = 0;
    longint            m_cycles  = 0;
    longint            m_retires = 0;
    bit                m_halted  = 1'b0;
    bit                m_timeout = 1'b0;
    logic [ADDR_W-1:0] m_hist[$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: actual %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic longint expRetire(input longint n);
        return RETIRE_ON ? n : 0;
    endfunction

    // Advances the model by one clock using the inputs sampled at this edge.
    task automatic modelStep();
        bit hit_halt;
        bit hit_to;
        if (rst) begin
            m_mode = M_IDLE; m_cycles = 0; m_retires = 0;
            m_halted = 0; m_timeout = 0; m_hist.delete();
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (start_i) begin
                    m_mode = M_RESET; m_rst_left = RST_CYCLES; m_elapsed = 0;
                    m_cycles = 0; m_retires = 0; m_halted = 0; m_timeout = 0;
                    m_hist.delete();
                end
                M_RESET: begin
                    if (abort_i) m_mode = M_IDLE;
                    else begin
                        m_rst_left--;
                        if (m_rst_left == 0) m_mode = M_RUN;
                    end
                end
                default: begin
                    if (abort_i) m_mode = M_IDLE;
                    else begin
                        m_elapsed++;
                        if (m_cycles < CNT_MAX) m_cycles++;
                        if (RETIRE_ON && retire_i && m_retires < CNT_MAX) m_retires++;
                        m_hist.push_back(pc_i);
                        if (m_hist.size() > HALT_STABLE) void'(m_hist.pop_front());
                        hit_halt = (m_hist.size() == HALT_STABLE);
                        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) hit_halt = 0;
                        hit_to = (RUN_CYCLES != 0) && (m_elapsed == RUN_CYCLES);
                        if (hit_halt || hit_to) begin
                            m_mode = M_DONE; m_halted = hit_halt; m_timeout = hit_to;
                        end
                    end
                end
            endcase
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("core_rst", 64'(core_rst_o), 64'((m_mode == M_IDLE) || (m_mode == M_RESET)));
            checkOutput("core_en", 64'(core_en_o), 64'(m_mode == M_RUN));
            checkOutput("busy", 64'(busy_o), 64'((m_mode == M_RESET) || (m_mode == M_RUN)));
            checkOutput("done", 64'(done_o), 64'(m_mode == M_DONE));
            checkOutput("halted", 64'(halted_o), 64'(m_halted));
            checkOutput("timeout", 64'(timeout_o), 64'(m_timeout));
            checkOutput("cycle_cnt", 64'(cycle_cnt_o), 64'(m_cycles));
            checkOutput("retire_cnt", 64'(retire_cnt_o), 64'(m_retires));
        end
    end

    // Drives one cycle of inputs, then returns just after the following
    // negedge so outputs reflect the edge that sampled these inputs.
    task automatic applyStimulus(input logic s, input logic a, input logic r,
                                 input logic [ADDR_W-1:0] p, input logic ret);
        start_i = s; abort_i = a; rst = r; pc_i = p; retire_i = ret;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        #1;
    endtask

    // Start pulse plus the reset window; retire pulses here must be ignored.
    task automatic enterRun();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        repeat (RST_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        @(negedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0);
        cmp_en = 1'b1;
        checkOutput("rst_core_rst", 64'(core_rst_o), 64'd1);
        checkOutput("rst_core_en", 64'(core_en_o), 64'd0);
        checkOutput("rst_cycle_cnt", 64'(cycle_cnt_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0);
        // abort and retire in IDLE are ignored
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Reset window: core_rst high for exactly RST_CYCLES after start
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("win1_core_rst", 64'(core_rst_o), 64'd1);
        checkOutput("win1_busy", 64'(busy_o), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("win2_core_rst", 64'(core_rst_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("run_core_rst", 64'(core_rst_o), 64'd0);
        checkOutput("run_core_en", 64'(core_en_o), 64'd1);
        checkOutput("run_busy", 64'(busy_o), 64'd1);

        // Timeout run: incrementing PC, 30 retires, start ignored mid-run
        for (int k = 0; k < 50; k++) begin
            applyStimulus(k == 25, 1'b0, 1'b0, 32'h1000 + 32'(4 * k), k < 30);
            if (k == 48) checkOutput("to_pre_done", 64'(done_o), 64'd0);
        end
        checkOutput("to_done", 64'(done_o), 64'd1);
        checkOutput("to_timeout", 64'(timeout_o), 64'd1);
        checkOutput("to_halted", 64'(halted_o), 64'd0);
        checkOutput("to_cycle_cnt", 64'(cycle_cnt_o), 64'd50);
        checkOutput("to_core_en", 64'(core_en_o), 64'd0);
        checkOutput("to_core_rst", 64'(core_rst_o), 64'd0);
        checkOutput("to_retire_cnt", 64'(retire_cnt_o), 64'(expRetire(30)));
        checkOutput("model_to_cycles", 64'(m_cycles), 64'd50);
        // DONE holds; abort ignored
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("done_hold_cnt", 64'(cycle_cnt_o), 64'd50);

        // Restart from DONE, then halt at PC 0x40 from RUN cycle 10
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("restart_cnt", 64'(cycle_cnt_o), 64'd0);
        checkOutput("restart_timeout", 64'(timeout_o), 64'd0);
        repeat (RST_CYCLES) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, (k < 10) ? 32'h2000 + 32'(4 * k) : 32'h40, 1'b1);
            if (k == 12) checkOutput("halt_pre_done", 64'(done_o), 64'd0);
        end
        checkOutput("halt_done", 64'(done_o), 64'd1);
        checkOutput("halt_halted", 64'(halted_o), 64'd1);
        checkOutput("halt_timeout", 64'(timeout_o), 64'd0);
        checkOutput("halt_cycle_cnt", 64'(cycle_cnt_o), 64'd14);
        checkOutput("halt_retire_cnt", 64'(retire_cnt_o), 64'(expRetire(14)));
        checkOutput("model_halted", 64'(m_halted), 64'd1);

        // Abort at RUN cycle 20
        enterRun();
        for (int k = 0; k < 20; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h3000 + 32'(4 * k), k < 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h3050, 1'b1);
        checkOutput("abort_core_rst", 64'(core_rst_o), 64'd1);
        checkOutput("abort_done", 64'(done_o), 64'd0);
        checkOutput("abort_busy", 64'(busy_o), 64'd0);
        checkOutput("abort_cycle_cnt", 64'(cycle_cnt_o), 64'd20);
        checkOutput("abort_flags", 64'({halted_o, timeout_o}), 64'd0);
        checkOutput("abort_retire_cnt", 64'(retire_cnt_o), 64'(expRetire(5)));
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("abort_hold_cnt", 64'(cycle_cnt_o), 64'd20);

        // Abort during RESET
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("rabort_busy", 64'(busy_o), 64'd0);
        checkOutput("rabort_cnt", 64'(cycle_cnt_o), 64'd0);

        // Synchronous reset at RUN cycle 7
        enterRun();
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h4000 + 32'(4 * k), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h401c, 1'b1);
        checkOutput("mrst_core_rst", 64'(core_rst_o), 64'd1);
        checkOutput("mrst_core_en", 64'(core_en_o), 64'd0);
        checkOutput("mrst_busy", 64'(busy_o), 64'd0);
        checkOutput("mrst_cnt", 64'(cycle_cnt_o), 64'd0);
        checkOutput("mrst_retire", 64'(retire_cnt_o), 64'd0);

        // Halt and timeout in the same cycle
        enterRun();
        for (int k = 0; k < 50; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, (k < 46) ? 32'h5000 + 32'(4 * k) : 32'h6000, 1'b0);
        checkOutput("both_halted", 64'(halted_o), 64'd1);
        checkOutput("both_timeout", 64'(timeout_o), 64'd1);
        checkOutput("both_cnt", 64'(cycle_cnt_o), 64'd50);

        // Abort beats a simultaneous halt and timeout
        enterRun();
        for (int k = 0; k < 50; k++)
            applyStimulus(1'b0, k == 49, 1'b0, (k < 46) ? 32'h7000 + 32'(4 * k) : 32'h8000, 1'b0);
        checkOutput("prio_flags", 64'({halted_o, timeout_o}), 64'd0);
        checkOutput("prio_done", 64'(done_o), 64'd0);
        checkOutput("prio_cnt", 64'(cycle_cnt_o), 64'd49);

        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
